// File: rtl/vc_wrr_if.sv
// Handshake bundle between the weighted round-robin VC scheduler and the FIFO bank around it.
// The scheduler connects to the master modport, and the surrounding FIFO logic or bench connects to the slave modport.
interface vc_wrr_if #(
    parameter int unsigned WGT_W = 3
);
    logic             en;
    logic             cfg_load;
    logic [WGT_W-1:0] wgt0;
    logic [WGT_W-1:0] wgt1;
    logic [WGT_W-1:0] wgt2;
    logic [WGT_W-1:0] wgt3;
    logic [3:0]       empty;
    logic [3:0]       afull;
    logic [3:0]       pop;
    logic [3:0]       push;
    logic [1:0]       sel;
    logic             busy;

    modport master (
        input  en, cfg_load, wgt0, wgt1, wgt2, wgt3, empty, afull,
        output pop, push, sel, busy
    );

    modport slave (
        output en, cfg_load, wgt0, wgt1, wgt2, wgt3, empty, afull,
        input  pop, push, sel, busy
    );
endinterface

// File: rtl/vc_wrr_scheduler.sv
// Weighted round-robin pop scheduler for four VC FIFOs, with the matching output push one cycle later.
// Per-VC credits count the grants left in the current turn; rr_ptr marks whose turn it is.
module vc_wrr_scheduler #(
    parameter int unsigned WGT_W   = 3,
    parameter int unsigned DEF_WGT = 1
) (
    input  logic      clk,
    input  logic      reset,
    vc_wrr_if.master  bus
);
    localparam int unsigned NVC   = 4;
    localparam int unsigned PTR_W = 2;

    typedef logic [WGT_W-1:0] wgt_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef enum logic {IDLE, RUN} state_t;

    // A weight of zero would stall its VC forever, so it counts as one.
    function automatic wgt_t eff_wgt(input wgt_t w);
        return (w == '0) ? wgt_t'(1) : w;
    endfunction

    localparam wgt_t DEF_EFF = (DEF_WGT == 0) ? wgt_t'(1) : wgt_t'(DEF_WGT);

    state_t     state_q;
    state_t     state_d;
    wgt_t       wgt_q    [NVC];
    wgt_t       credit_q [NVC];
    wgt_t       credit_d [NVC];
    wgt_t       wgt_in   [NVC];
    ptr_t       rr_q;
    ptr_t       rr_d;
    ptr_t       gnt_idx;
    ptr_t       cand;
    logic       found;
    logic       cfg_en;
    logic [3:0] elig;
    logic [3:0] grant;
    logic [3:0] pop_q;
    logic [3:0] push_q;
    logic [1:0] sel_q;
    logic       busy_q;

    assign wgt_in[0] = bus.wgt0;
    assign wgt_in[1] = bus.wgt1;
    assign wgt_in[2] = bus.wgt2;
    assign wgt_in[3] = bus.wgt3;

    assign cfg_en = (state_q == IDLE) && bus.cfg_load;
    assign elig   = {4{(state_q == RUN) && bus.en}} & ~bus.empty & ~bus.afull;

    // Next-state, credit and grant decision.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        rr_d     = rr_q;
        grant    = '0;
        gnt_idx  = rr_q;
        cand     = rr_q;
        found    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d = RUN;
                end
                if (cfg_en) begin
                    for (int i = 0; i < NVC; i++) begin
                        credit_d[i] = eff_wgt(wgt_in[i]);
                    end
                end
            end
            RUN: begin
                if (!bus.en) begin
                    state_d = IDLE;
                end
                if (elig[rr_q] && (credit_q[rr_q] != '0)) begin
                    gnt_idx = rr_q;
                    found   = 1'b1;
                end else begin
                    for (int k = 1; k < NVC; k++) begin
                        cand = rr_q + PTR_W'(k);
                        if (!found && elig[cand]) begin
                            gnt_idx = cand;
                            found   = 1'b1;
                        end
                    end
                    // The current VC forfeits the rest of its turn only if someone else gets served.
                    if (found) begin
                        credit_d[rr_q] = wgt_q[rr_q];
                    end
                end
                if (found) begin
                    grant[gnt_idx] = 1'b1;
                    if (credit_q[gnt_idx] <= wgt_t'(1)) begin
                        credit_d[gnt_idx] = wgt_q[gnt_idx];
                        rr_d              = gnt_idx + PTR_W'(1);
                    end else begin
                        credit_d[gnt_idx] = credit_q[gnt_idx] - wgt_t'(1);
                        rr_d              = gnt_idx;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, credits, weights and the pop -> push pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            pop_q   <= '0;
            push_q  <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            for (int i = 0; i < NVC; i++) begin
                wgt_q[i]    <= DEF_EFF;
                credit_q[i] <= DEF_EFF;
            end
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            credit_q <= credit_d;
            pop_q    <= grant;
            push_q   <= pop_q;
            busy_q   <= (state_d == RUN) || (pop_q != '0);
            if (cfg_en) begin
                for (int i = 0; i < NVC; i++) begin
                    wgt_q[i] <= eff_wgt(wgt_in[i]);
                end
            end
            case (pop_q)
                4'b0001: sel_q <= 2'd0;
                4'b0010: sel_q <= 2'd1;
                4'b0100: sel_q <= 2'd2;
                4'b1000: sel_q <= 2'd3;
                default: sel_q <= sel_q;
            endcase
        end
    end

    assign bus.pop  = pop_q;
    assign bus.push = push_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_vc_wrr_scheduler.sv
// Bench for vc_wrr_scheduler: a pop table per cycle drives a scoreboard that checks pop now and the matching push/sel a cycle later.
module tb_vc_wrr_scheduler;
    typedef struct {
        logic       en;
        logic [3:0] empty;
        logic [3:0] afull;
        logic [3:0] exp_pop;
    } vec_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    logic [3:0] sb [$];
    logic [3:0] last_exp;
    vec_t       tbl [$];

    vc_wrr_if #(.WGT_W(3)) bus ();

    vc_wrr_scheduler #(.WGT_W(3), .DEF_WGT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic en, input logic [3:0] empty,
                                input logic [3:0] afull, input logic [3:0] exp_pop);
        vec_t v;
        v.en = en; v.empty = empty; v.afull = afull; v.exp_pop = exp_pop;
        return v;
    endfunction

    function automatic logic [1:0] enc(input logic [3:0] oh);
        case (oh)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    // One cycle: drive inputs, let an edge pass, then compare pop now and push/sel from the previous grant.
    task automatic step(input string tag, input logic en, input logic [3:0] empty,
                        input logic [3:0] afull, input logic [3:0] exp_pop);
        logic [3:0] exp_now;
        bus.en    = en;
        bus.empty = empty;
        bus.afull = afull;
        sb.push_back(exp_pop);
        @(posedge clk);
        #1;
        exp_now = sb.pop_front();
        check({tag, " pop"}, 8'(bus.pop), 8'(exp_now));
        check({tag, " push"}, 8'(bus.push), 8'(last_exp));
        if (last_exp != 4'b0000) begin
            check({tag, " sel"}, 8'(bus.sel), 8'(enc(last_exp)));
        end
        last_exp = exp_now;
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            step($sformatf("%s[%0d]", tag, i), tbl[i].en, tbl[i].empty, tbl[i].afull, tbl[i].exp_pop);
        end
        tbl.delete();
    endtask

    task automatic load_wgt(input string tag, input logic [2:0] a, input logic [2:0] b,
                            input logic [2:0] c, input logic [2:0] d);
        bus.wgt0 = a; bus.wgt1 = b; bus.wgt2 = c; bus.wgt3 = d;
        bus.cfg_load = 1'b1;
        step(tag, 1'b0, 4'h0, 4'h0, 4'h0);
        bus.cfg_load = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        last_exp = 4'b0000;
        reset = 1'b0;
        bus.en = 1'b0; bus.cfg_load = 1'b0;
        bus.wgt0 = '0; bus.wgt1 = '0; bus.wgt2 = '0; bus.wgt3 = '0;
        bus.empty = 4'hF; bus.afull = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset pop", 8'(bus.pop), 8'h0);
        check("reset push", 8'(bus.push), 8'h0);
        check("reset sel", 8'(bus.sel), 8'h0);
        check("reset busy", 8'(bus.busy), 8'h0);
        reset = 1'b1;

        // T1: default weights rotate one grant per VC.
        tbl.push_back(mk(1'b1, 4'h0, 4'h0, 4'b0000));
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < 4; v++) begin
                tbl.push_back(mk(1'b1, 4'h0, 4'h0, 4'(1 << v)));
            end
        end
        tbl.push_back(mk(1'b0, 4'h0, 4'h0, 4'b0000));
        run_table("t1");
        check("t1 busy during last push", 8'(bus.busy), 8'h1);
        step("t1 drain", 1'b0, 4'h0, 4'h0, 4'h0);
        check("t1 busy idle", 8'(bus.busy), 8'h0);

        // T2: weights 3,1,2,1.
        load_wgt("t2 cfg", 3'd3, 3'd1, 3'd2, 3'd1);
        tbl.push_back(mk(1'b1, 4'h0, 4'h0, 4'b0000));
        for (int r = 0; r < 2; r++) begin
            tbl.push_back(mk(1'b1, 4'h0, 4'h0, 4'b0001));
            tbl.push_back(mk(1'b1, 4'h0, 4'h0, 4'b0001));
            tbl.push_back(mk(1'b1, 4'h0, 4'h0, 4'b0001));
            tbl.push_back(mk(1'b1, 4'h0, 4'h0, 4'b0010));
            tbl.push_back(mk(1'b1, 4'h0, 4'h0, 4'b0100));
            tbl.push_back(mk(1'b1, 4'h0, 4'h0, 4'b0100));
            tbl.push_back(mk(1'b1, 4'h0, 4'h0, 4'b1000));
        end
        tbl.push_back(mk(1'b0, 4'h0, 4'h0, 4'b0000));
        tbl.push_back(mk(1'b0, 4'h0, 4'h0, 4'b0000));
        run_table("t2");

        // T3: P0 empties mid-turn, later returns with a full credit of 3.
        load_wgt("t3 cfg", 3'd3, 3'd1, 3'd1, 3'd1);
        step("t3 start", 1'b1, 4'h0, 4'h0, 4'b0000);
        step("t3 p0 first", 1'b1, 4'h0, 4'h0, 4'b0001);
        step("t3 skip p0", 1'b1, 4'b0001, 4'h0, 4'b0010);
        step("t3 p2", 1'b1, 4'b0001, 4'h0, 4'b0100);
        step("t3 p3", 1'b1, 4'b0001, 4'h0, 4'b1000);
        step("t3 p0 back a", 1'b1, 4'h0, 4'h0, 4'b0001);
        step("t3 p0 back b", 1'b1, 4'h0, 4'h0, 4'b0001);
        step("t3 p0 back c", 1'b1, 4'h0, 4'h0, 4'b0001);
        step("t3 p1 after", 1'b1, 4'h0, 4'h0, 4'b0010);
        step("t3 stop", 1'b0, 4'h0, 4'h0, 4'b0000);
        step("t3 drain", 1'b0, 4'h0, 4'h0, 4'b0000);

        // T4: everything almost full, then only P2 frees up.
        step("t4 start", 1'b1, 4'h0, 4'hF, 4'b0000);
        for (int c = 0; c < 3; c++) begin
            step($sformatf("t4 blocked%0d", c), 1'b1, 4'h0, 4'hF, 4'b0000);
        end
        step("t4 p2 free", 1'b1, 4'h0, 4'b1011, 4'b0100);
        step("t4 push p2", 1'b1, 4'h0, 4'hF, 4'b0000);
        step("t4 stop", 1'b0, 4'h0, 4'hF, 4'b0000);

        // T5: en drops in the cycle pop=0010 is visible.
        step("t5 start", 1'b1, 4'b1101, 4'h0, 4'b0000);
        step("t5 p1", 1'b1, 4'b1101, 4'h0, 4'b0010);
        step("t5 en low", 1'b0, 4'b1101, 4'h0, 4'b0000);
        step("t5 after", 1'b0, 4'b1101, 4'h0, 4'b0000);
        check("t5 busy after push", 8'(bus.busy), 8'h0);

        // T6: reset while pop=1000 is waiting for its push.
        step("t6 start", 1'b1, 4'b0111, 4'h0, 4'b0000);
        step("t6 p3", 1'b1, 4'b0111, 4'h0, 4'b1000);
        reset = 1'b0;
        #1;
        check("t6 rst pop", 8'(bus.pop), 8'h0);
        check("t6 rst push", 8'(bus.push), 8'h0);
        check("t6 rst busy", 8'(bus.busy), 8'h0);
        @(posedge clk);
        #1;
        check("t6 rst push held", 8'(bus.push), 8'h0);
        sb.delete();
        last_exp = 4'b0000;
        reset = 1'b1;
        tbl.push_back(mk(1'b1, 4'h0, 4'h0, 4'b0000));
        for (int v = 0; v < 4; v++) begin
            tbl.push_back(mk(1'b1, 4'h0, 4'h0, 4'(1 << v)));
        end
        tbl.push_back(mk(1'b0, 4'h0, 4'h0, 4'b0000));
        tbl.push_back(mk(1'b0, 4'h0, 4'h0, 4'b0000));
        run_table("t6 post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
